// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared encodings and helpers for the snake step scheduler
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_UP    = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_e;

  localparam logic [2:0] ST_START = 3'b001;
  localparam logic [2:0] ST_PLAY  = 3'b010;
  localparam logic [2:0] ST_END   = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_WAIT_ACK,
    S_HALT
  } sched_state_e;

  function automatic dir_e reverse_dir(input dir_e d);
    case (d)
      DIR_RIGHT: return DIR_LEFT;
      DIR_LEFT:  return DIR_RIGHT;
      DIR_UP:    return DIR_DOWN;
      default:   return DIR_UP;
    endcase
  endfunction

endpackage

// File: rtl/step_timer.sv
// rtl/step_timer.sv - move-step period counter with terminal count
module step_timer #(
  parameter int CW = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr,
  input  logic [CW:0] period,
  output logic        tc
);

  localparam int PW = CW + 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // A level-up can shrink the period below the running count; >= fires the
  // step at once instead of letting the counter wrap through its full range.
  assign tc = ({1'b0, cnt_q} >= (period - PW'(1)));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/snake_step_sched.sv
// rtl/snake_step_sched.sv - snake heading, step cadence, score and level scheduler
module snake_step_sched
  import snake_pkg::*;
#(
  parameter int STEP_BASE     = 12_500_000,
  parameter int STEP_DEC      = 2_000_000,
  parameter int LEVEL_MAX     = 4,
  parameter int EAT_PER_LEVEL = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] game_status,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       eat,
  input  logic       step_ack,
  output logic       step_req,
  output logic [1:0] dir,
  output logic [7:0] score,
  output logic [2:0] level
);

  localparam int CW = $clog2(STEP_BASE);
  localparam int PW = CW + 1;
  localparam int EW = $clog2(EAT_PER_LEVEL + 1);
  localparam logic [2:0]    LVL_MAX  = 3'(LEVEL_MAX);
  localparam logic [EW-1:0] EAT_LAST = EW'(EAT_PER_LEVEL - 1);

  sched_state_e  state_q, state_d;
  logic          step_req_q, step_req_d;
  dir_e          dir_q, dir_d;
  dir_e          dir_next_q, dir_next_d;
  logic [7:0]    score_q, score_d;
  logic [2:0]    level_q, level_d;
  logic [EW-1:0] eat_cnt_q, eat_cnt_d;

  logic [PW-1:0] period;
  logic          timer_en, timer_tc;
  logic          is_play, is_end, is_start, active;
  logic          key_any;
  dir_e          key_dir;

  assign period = PW'(STEP_BASE - int'(level_q) * STEP_DEC);

  step_timer #(.CW(CW)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .en     (timer_en),
    .clr    (~timer_en),
    .period (period),
    .tc     (timer_tc)
  );

  // Anything that is not a clean PLAY or END code falls back to START.
  assign is_play  = (game_status == ST_PLAY);
  assign is_end   = (game_status == ST_END);
  assign is_start = ~(is_play | is_end);
  assign active   = (state_q == S_RUN) || (state_q == S_WAIT_ACK);
  assign key_any  = key_up | key_down | key_left | key_right;

  always_comb begin
    if (key_up)        key_dir = DIR_UP;
    else if (key_down) key_dir = DIR_DOWN;
    else if (key_left) key_dir = DIR_LEFT;
    else               key_dir = DIR_RIGHT;
  end

  always_comb begin
    state_d    = state_q;
    step_req_d = step_req_q;
    dir_d      = dir_q;
    dir_next_d = dir_next_q;
    score_d    = score_q;
    level_d    = level_q;
    eat_cnt_d  = eat_cnt_q;
    timer_en   = 1'b0;

    if (active) begin
      // Validity is judged against the committed heading, so two quick
      // presses cannot reverse the snake within one step.
      if (key_any && (key_dir != reverse_dir(dir_q))) begin
        dir_next_d = key_dir;
      end
      if (eat) begin
        if (score_q != 8'hFF) score_d = score_q + 8'd1;
        if (eat_cnt_q == EAT_LAST) begin
          eat_cnt_d = '0;
          if (level_q < LVL_MAX) level_d = level_q + 3'd1;
        end else begin
          eat_cnt_d = eat_cnt_q + EW'(1);
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (is_play) begin
          state_d    = S_RUN;
          dir_d      = DIR_RIGHT;
          dir_next_d = DIR_RIGHT;
          score_d    = '0;
          level_d    = '0;
          eat_cnt_d  = '0;
        end
      end
      S_RUN: begin
        if (is_start) begin
          state_d    = S_IDLE;
          step_req_d = 1'b0;
        end else if (is_end) begin
          state_d = S_HALT;
        end else begin
          timer_en = 1'b1;
          if (timer_tc) begin
            dir_d      = dir_next_q;
            step_req_d = 1'b1;
            state_d    = S_WAIT_ACK;
          end
        end
      end
      S_WAIT_ACK: begin
        if (is_start) begin
          state_d    = S_IDLE;
          step_req_d = 1'b0;
        end else if (is_end) begin
          state_d    = S_HALT;
          step_req_d = 1'b0;
        end else if (step_ack) begin
          state_d    = S_RUN;
          step_req_d = 1'b0;
        end
      end
      default: begin
        if (is_start) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      step_req_q <= 1'b0;
      dir_q      <= DIR_RIGHT;
      dir_next_q <= DIR_RIGHT;
      score_q    <= '0;
      level_q    <= '0;
      eat_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      step_req_q <= step_req_d;
      dir_q      <= dir_d;
      dir_next_q <= dir_next_d;
      score_q    <= score_d;
      level_q    <= level_d;
      eat_cnt_q  <= eat_cnt_d;
    end
  end

  assign step_req = step_req_q;
  assign dir      = dir_q;
  assign score    = score_q;
  assign level    = level_q;

endmodule
